// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate truth-table checker.
// FSM state encoding plus the common 2-input truth tables.
// Imported by gate_tt_checker and gate_tt_settle_timer.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit i is the expected gate output for stimulus value i.
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Settle countdown: load starts a window of SETTLE_CYCLES cycles.
// Latency: expired rises in the last cycle of the window (1 cycle after load when SETTLE_CYCLES=1).
// No backpressure; a load while counting restarts the window.
module gate_tt_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Count down from SETTLE_CYCLES-1 so that expired marks the final settle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(SETTLE_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps every input vector of a gate under test and compares its output to TRUTH_TABLE.
// Latency: done rises 2**N_IN*(SETTLE_CYCLES+1)+1 cycles after start is accepted.
// start is only honoured in IDLE; optional per-vector fail bitmap via GATE_TT_CHECKER_FAIL_MAP_EN.
module gate_tt_checker
  import gate_check_pkg::*;
#(
  parameter int                 N_IN          = 2,
  parameter logic [2**N_IN-1:0] TRUTH_TABLE   = TT_NAND2,
  parameter int                 SETTLE_CYCLES = 2,
  parameter int                 ERR_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic                 first_fail_vld,
  output logic [2**N_IN-1:0]   fail_map
);

  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [N_IN-1:0]  IDX_LAST = '1;

  state_t            state;
  state_t            state_nxt;
  logic [N_IN-1:0]   idx;
  logic [ERR_W-1:0]  err_nxt;
  logic              accept;
  logic              last;
  logic              mismatch;
  logic              load;
  logic              expired;

  assign accept   = (state == IDLE) && start;
  assign last     = (idx == IDX_LAST);
  assign mismatch = (state == SAMPLE) && (dut_out != TRUTH_TABLE[idx]);
  assign load     = accept || ((state == SAMPLE) && !last);

  gate_tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: settle, sample, advance to next vector or finish.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (expired) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating error increment for the vector being sampled.
  always_comb begin
    err_nxt = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_nxt = err_count + ERR_W'(1);
    end
  end

  // Vector index, error count, first-failure capture and pass verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      err_count      <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (accept) begin
      idx            <= '0;
      err_count      <= '0;
      first_fail_vld <= 1'b0;
      pass           <= 1'b0;
    end else if (state == SAMPLE) begin
      err_count <= err_nxt;
      if (mismatch && !first_fail_vld) begin
        first_fail_vld <= 1'b1;
        first_fail_idx <= idx;
      end
      // Verdict is taken on the final sample so it is already valid while done is high.
      if (last) begin
        pass <= (err_nxt == '0);
      end else begin
        idx <= idx + N_IN'(1);
      end
    end
  end

`ifdef GATE_TT_CHECKER_FAIL_MAP_EN
  logic [2**N_IN-1:0] fail_map_q;

  // Per-vector mismatch bitmap, cleared at the start of each sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_map_q <= '0;
    end else if (accept) begin
      fail_map_q <= '0;
    end else if (mismatch) begin
      fail_map_q[idx] <= 1'b1;
    end
  end

  assign fail_map = fail_map_q;
`else
  assign fail_map = '0;
`endif

  // Stimulus is the vector index register itself, so it changes on the same edge as idx.
  assign stim = idx;
  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);

endmodule
